// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the write-back stage and its neighbours.
//   Holds the data/address/PC widths, the source-select encodings, the
//   write-back bus field positions (also used by decode) and the RET FSM state type.
package wb_pkg;
    localparam int DATA_W     = 16;
    localparam int RADDR_W    = 3;
    localparam int PC_W       = 2 * DATA_W;
    localparam int WB_W       = 1 + DATA_W + RADDR_W;
    localparam int WB_EN      = 19;
    localparam int WB_DATA_HI = 18;
    localparam int WB_DATA_LO = 3;
    localparam int WB_ADDR_HI = 2;
    localparam int WB_ADDR_LO = 0;
    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_IN  = 2'd2;
    typedef enum logic {IDLE = 1'b0, HIGH = 1'b1} ret_state_t;
endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: memory-stage inputs and write-back/redirect outputs of the write-back stage.
//   master: memory-stage side, drives mem_* and observes results.
//   slave : write-back stage, consumes mem_* and drives writeback, out_port,
//           pc_load, pc_value, flags_restore, ret_busy, ret_err, retired.
interface writeback_stage_if;
    import wb_pkg::*;
    logic               mem_valid;
    logic               mem_wb;
    logic [RADDR_W-1:0] mem_rdst;
    logic [DATA_W-1:0]  mem_alu;
    logic [DATA_W-1:0]  mem_rdata;
    logic [DATA_W-1:0]  mem_inport;
    logic [1:0]         mem_sel;
    logic               mem_out;
    logic               mem_ret;
    logic               mem_rti;
    logic [WB_W-1:0]    writeback;
    logic [DATA_W-1:0]  out_port;
    logic               pc_load;
    logic [PC_W-1:0]    pc_value;
    logic               flags_restore;
    logic               ret_busy;
    logic               ret_err;
    logic [DATA_W-1:0]  retired;
    modport master (
        output mem_valid, mem_wb, mem_rdst, mem_alu, mem_rdata, mem_inport,
               mem_sel, mem_out, mem_ret, mem_rti,
        input  writeback, out_port, pc_load, pc_value, flags_restore,
               ret_busy, ret_err, retired
    );
    modport slave (
        input  mem_valid, mem_wb, mem_rdst, mem_alu, mem_rdata, mem_inport,
               mem_sel, mem_out, mem_ret, mem_rti,
        output writeback, out_port, pc_load, pc_value, flags_restore,
               ret_busy, ret_err, retired
    );
endinterface

// File: rtl/writeback_stage_ret_assembler.sv
// ret_assembler: joins the two 16-bit RET/RTI stack pops (high word first) into a 32-bit PC redirect.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid, i_ret, i_rti, i_rdata : memory-stage slot qualifiers and popped word
//   o_pc_load, o_pc_value, o_flags_restore : redirect strobe, target, RTI flag restore
//   o_ret_busy : first beat held, waiting for second; o_ret_err : aborted sequence pulse
module ret_assembler
    import wb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_ret,
    input  logic              i_rti,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_pc_load,
    output logic [PC_W-1:0]   o_pc_value,
    output logic              o_flags_restore,
    output logic              o_ret_busy,
    output logic              o_ret_err
);
    ret_state_t        r_state, w_next;
    logic [DATA_W-1:0] r_hi, w_hi;
    logic [PC_W-1:0]   r_pc, w_pc;
    logic              r_load, r_flags, r_err;
    logic              w_load, w_flags, w_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_pc    <= '0;
            r_load  <= 1'b0;
            r_flags <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hi    <= w_hi;
            r_pc    <= w_pc;
            r_load  <= w_load;
            r_flags <= w_flags;
            r_err   <= w_err;
        end
    end

    // Bubbles (i_valid=0) leave everything as is, so HIGH waits across them.
    always_comb begin
        w_next  = r_state;
        w_hi    = r_hi;
        w_pc    = r_pc;
        w_load  = 1'b0;
        w_flags = 1'b0;
        w_err   = 1'b0;
        if (i_valid) begin
            if (r_state == IDLE) begin
                if (i_ret) begin
                    w_hi   = i_rdata;
                    w_next = HIGH;
                end
            end else if (i_ret) begin
                w_pc    = {r_hi, i_rdata};
                w_load  = 1'b1;
                w_flags = i_rti;
                w_next  = IDLE;
            end else begin
                w_err  = 1'b1;
                w_next = IDLE;
            end
        end
    end

    assign o_pc_load       = r_load;
    assign o_pc_value      = r_pc;
    assign o_flags_restore = r_flags;
    assign o_ret_busy      = (r_state == HIGH);
    assign o_ret_err       = r_err;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage; registers the write-back bus, OUT port, retire count and RET redirect.
//   Clk : clock, rising edge
//   Rst : async active-low reset
//   bus : writeback_stage_if slave (mem_* in; writeback, out_port, redirect, retired out)
module writeback_stage
    import wb_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    writeback_stage_if.slave bus
);
    logic [WB_W-1:0]   r_wb;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_retired;
    logic [DATA_W-1:0] w_data;
    logic              w_pc_load, w_flags, w_busy, w_err;
    logic [PC_W-1:0]   w_pc;

    // Reserved select 3 falls through to the ALU result.
    assign w_data = (bus.mem_sel == SEL_MEM) ? bus.mem_rdata :
                    (bus.mem_sel == SEL_IN)  ? bus.mem_inport : bus.mem_alu;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wb      <= '0;
            r_out     <= '0;
            r_retired <= '0;
        end else begin
            r_wb[WB_EN] <= bus.mem_valid & bus.mem_wb & ~bus.mem_ret;
            if (bus.mem_valid) begin
                r_wb[WB_DATA_HI:WB_DATA_LO] <= w_data;
                r_wb[WB_ADDR_HI:WB_ADDR_LO] <= bus.mem_rdst;
            end
            if (bus.mem_valid & bus.mem_out)
                r_out <= bus.mem_alu;
            // A RET pop counts only on its second beat, i.e. while the assembler is busy.
            if (bus.mem_valid & (~bus.mem_ret | w_busy))
                r_retired <= r_retired + 1'b1;
        end
    end

    ret_assembler u_ret (
        .i_clk           (Clk),
        .i_rst_n         (Rst),
        .i_valid         (bus.mem_valid),
        .i_ret           (bus.mem_ret),
        .i_rti           (bus.mem_rti),
        .i_rdata         (bus.mem_rdata),
        .o_pc_load       (w_pc_load),
        .o_pc_value      (w_pc),
        .o_flags_restore (w_flags),
        .o_ret_busy      (w_busy),
        .o_ret_err       (w_err)
    );

    assign bus.writeback     = r_wb;
    assign bus.out_port      = r_out;
    assign bus.retired       = r_retired;
    assign bus.pc_load       = w_pc_load;
    assign bus.pc_value      = w_pc;
    assign bus.flags_restore = w_flags;
    assign bus.ret_busy      = w_busy;
    assign bus.ret_err       = w_err;
endmodule
